// File: rtl/ennemy_wave.sv
// ennemy_wave: N-slot enemy generator for the shooter playfield.
// Slots spawn at staggered intervals on rotating lanes, fall on the game
// tick, and leave on collision (hit) or on reaching the bottom (avoided).
// Optional build macro ENNEMY_SPEEDUP_EN: fall speed rises by one row/tick
// every 8 spawns (saturating at 4). Without it, speed is fixed at 1.
module ennemy_wave #(
  parameter int N           = 4,
  parameter int Y_MAX       = 238,
  parameter int X_BASE      = 72,
  parameter int X_SPAN      = 128,
  parameter int X_STEP      = 51,
  parameter int SPAWN_GAP   = 60,
  parameter int OFFSCREEN_X = 400
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clk_en,
  input  logic [1:0]     scene,
  input  logic [N-1:0]   colision,
  output logic [9*N-1:0] X,
  output logic [9*N-1:0] Y,
  output logic [N-1:0]   alive,
  output logic [N-1:0]   avoided,
  output logic [N-1:0]   hit,
  output logic [2:0]     speed
);

  localparam logic [1:0] PLAY = 2'd1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FALL = 1'b1;

  localparam int GW = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(SPAWN_GAP - 1);

  localparam logic [8:0] Y_MAX9  = 9'(Y_MAX);
  localparam logic [9:0] Y_MAX10 = 10'(Y_MAX);
  localparam logic [8:0] OFF_X   = 9'(OFFSCREEN_X);
  localparam logic [7:0] SPAN8   = 8'(X_SPAN);
  localparam logic [7:0] STEP8   = 8'(X_STEP);

  logic [0:0]    state [N];
  logic [8:0]    x_q   [N];
  logic [8:0]    y_q   [N];
  logic [8:0]    y_next[N];
  logic [9:0]    y_sum;

  logic [GW-1:0] gap;
  logic [6:0]    k;
  logic [7:0]    k_sum;
  logic [8:0]    spawn_x;

  logic [N-1:0]  spawn_sel;
  logic          found;
  logic          spawn_try;
  logic          spawn_ok;
  logic          playing;

  assign playing   = (scene == PLAY);
  assign spawn_try = playing && clk_en && (gap == GAP_LAST);
  assign spawn_ok  = spawn_try && found;
  assign k_sum     = {1'b0, k} + STEP8;
  assign spawn_x   = 9'(X_BASE) + {2'b00, k};

  // Lowest-index idle slot, judged on pre-edge state so a slot freed on this
  // edge only becomes eligible on the following one.
  always_comb begin
    spawn_sel = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (state[i] == IDLE && !found) begin
        spawn_sel[i] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  // Next fall position: 10-bit add then clamp onto the bottom row.
  always_comb begin
    y_sum = '0;
    for (int unsigned i = 0; i < N; i++) begin
      y_sum     = {1'b0, y_q[i]} + {7'd0, speed};
      y_next[i] = (y_sum > Y_MAX10) ? Y_MAX9 : y_sum[8:0];
    end
  end

  // Per-slot FSM: rst > leave PLAY > collision > bottom > move / spawn.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        state[i] <= IDLE;
        x_q[i]   <= OFF_X;
        y_q[i]   <= '0;
      end
      avoided <= '0;
      hit     <= '0;
    end else begin
      avoided <= '0;
      hit     <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        if (!playing) begin
          state[i] <= IDLE;
          x_q[i]   <= OFF_X;
          y_q[i]   <= '0;
        end else if (state[i] == FALL) begin
          if (colision[i]) begin
            state[i] <= IDLE;
            x_q[i]   <= OFF_X;
            y_q[i]   <= '0;
            hit[i]   <= 1'b1;
          end else if (y_q[i] == Y_MAX9) begin
            state[i]   <= IDLE;
            x_q[i]     <= OFF_X;
            y_q[i]     <= '0;
            avoided[i] <= 1'b1;
          end else if (clk_en) begin
            y_q[i] <= y_next[i];
          end
        end else if (spawn_ok && spawn_sel[i]) begin
          state[i] <= FALL;
          x_q[i]   <= spawn_x;
          y_q[i]   <= '0;
        end
      end
    end
  end

  // Spawn gap timer: counts ticks in PLAY, clears outside PLAY.
  always_ff @(posedge clk) begin
    if (rst || !playing) begin
      gap <= '0;
    end else if (clk_en) begin
      gap <= (gap == GAP_LAST) ? '0 : gap + 1'b1;
    end
  end

  // Lane offset: advances only on a successful spawn, wrapping past X_SPAN.
  always_ff @(posedge clk) begin
    if (rst) begin
      k <= '0;
    end else if (spawn_ok) begin
      k <= (k_sum <= SPAN8) ? k_sum[6:0] : 7'(k_sum - SPAN8);
    end
  end

`ifdef ENNEMY_SPEEDUP_EN
  logic [2:0] spawn_cnt;

  // Speed ramp: every 8th spawn bumps speed, capped at 4; held outside PLAY.
  always_ff @(posedge clk) begin
    if (rst) begin
      spawn_cnt <= '0;
      speed     <= 3'd1;
    end else if (spawn_ok) begin
      spawn_cnt <= spawn_cnt + 3'd1;
      if (spawn_cnt == 3'd7 && speed < 3'd4) begin
        speed <= speed + 3'd1;
      end
    end
  end
`else
  assign speed = 3'd1;
`endif

  // Flatten slot registers onto the packed output buses.
  always_comb begin
    X     = '0;
    Y     = '0;
    alive = '0;
    for (int unsigned i = 0; i < N; i++) begin
      X[9*i +: 9] = x_q[i];
      Y[9*i +: 9] = y_q[i];
      alive[i]    = (state[i] == FALL);
    end
  end

endmodule
